// File: rtl/tournament_predictor_if.sv
// tournament_predictor_if: lookup/update/prediction signals between fetch, ROB and the predictor
interface tournament_predictor_if #(
    parameter int HISTORY_WIDTH = 8
);
    logic                     instrInValid;
    logic [31:0]              instrAddr;
    logic                     updateValid;
    logic [31:0]              updateInstr;
    logic [HISTORY_WIDTH-1:0] updateHistory;
    logic                     taken;
    logic                     mispredict;
    logic                     ready;
    logic                     predValid;
    logic                     jump;
    logic [HISTORY_WIDTH-1:0] predHistory;

    modport master (
        output instrInValid, instrAddr, updateValid, updateInstr, updateHistory, taken, mispredict,
        input  ready, predValid, jump, predHistory
    );

    modport slave (
        input  instrInValid, instrAddr, updateValid, updateInstr, updateHistory, taken, mispredict,
        output ready, predValid, jump, predHistory
    );
endinterface

// File: rtl/tournament_predictor.sv
// tournament_predictor: bimodal + gshare direction predictor with per-address chooser
module tournament_predictor #(
    parameter int INDEX_WIDTH   = 10,
    parameter int HISTORY_WIDTH = 8,
    parameter int CNT_WIDTH     = 2
) (
    input logic                   clockIn,
    input logic                   resetIn,
    tournament_predictor_if.slave bp
);
    localparam int N = 2 ** INDEX_WIDTH;
    localparam logic [CNT_WIDTH-1:0] WEAK = {1'b0, {(CNT_WIDTH-1){1'b1}}};

    typedef enum logic {INIT, RUN} state_t;

    state_t                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]   sweep_q, sweep_d;
    logic [HISTORY_WIDTH-1:0] ghr_q, ghr_d, pred_hist_q, pred_hist_d;
    logic                     pred_valid_q, pred_valid_d, jump_q, jump_d;
    logic [CNT_WIDTH-1:0]     bim_q [N];
    logic [CNT_WIDTH-1:0]     gsh_q [N];
    logic [CNT_WIDTH-1:0]     cho_q [N];
    logic                     lookup, update, lk_jump, up_b_msb, up_g_msb;
    logic [INDEX_WIDTH-1:0]   lk_b, lk_g, up_b, up_g;
    logic                     unused_addr_bits;

    function automatic logic [CNT_WIDTH-1:0] sat_step(input logic [CNT_WIDTH-1:0] c, input logic up);
        return up ? (&c ? c : c + CNT_WIDTH'(1)) : (|c ? c - CNT_WIDTH'(1) : c);
    endfunction

    assign bp.ready       = state_q == RUN;
    assign bp.predValid   = pred_valid_q;
    assign bp.jump        = jump_q;
    assign bp.predHistory = pred_hist_q;

    assign lookup   = bp.ready && bp.instrInValid;
    assign update   = bp.ready && bp.updateValid;
    assign lk_b     = bp.instrAddr[INDEX_WIDTH+1:2];
    assign lk_g     = lk_b ^ INDEX_WIDTH'(ghr_q);
    assign up_b     = bp.updateInstr[INDEX_WIDTH+1:2];
    assign up_g     = up_b ^ INDEX_WIDTH'(bp.updateHistory);
    assign lk_jump  = cho_q[lk_b][CNT_WIDTH-1] ? gsh_q[lk_g][CNT_WIDTH-1] : bim_q[lk_b][CNT_WIDTH-1];
    assign up_b_msb = bim_q[up_b][CNT_WIDTH-1];
    assign up_g_msb = gsh_q[up_g][CNT_WIDTH-1];

    assign unused_addr_bits = ^{bp.instrAddr[31:INDEX_WIDTH+2], bp.instrAddr[1:0],
                                bp.updateInstr[31:INDEX_WIDTH+2], bp.updateInstr[1:0]};

    // control state, history and registered prediction; reset takes effect immediately
    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            state_q      <= INIT;
            sweep_q      <= '0;
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            jump_q       <= 1'b0;
            pred_hist_q  <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            jump_q       <= jump_d;
            pred_hist_q  <= pred_hist_d;
        end
    end

    // tables: initialised by the sweep, trained by resolved branches; reads are pre-write
    always_ff @(posedge clockIn) begin
        if (state_q == INIT) begin
            bim_q[sweep_q] <= WEAK;
            gsh_q[sweep_q] <= WEAK;
            cho_q[sweep_q] <= WEAK;
        end else if (update) begin
            bim_q[up_b] <= sat_step(bim_q[up_b], bp.taken);
            gsh_q[up_g] <= sat_step(gsh_q[up_g], bp.taken);
            if (up_b_msb != up_g_msb)
                cho_q[up_b] <= sat_step(cho_q[up_b], up_g_msb == bp.taken);
        end
    end

    // sweep sequencing, speculative history shift with mispredict repair, prediction capture
    always_comb begin
        state_d      = (state_q == INIT && &sweep_q) ? RUN : state_q;
        sweep_d      = state_q == INIT ? sweep_q + INDEX_WIDTH'(1) : sweep_q;
        ghr_d        = (update && bp.mispredict) ? HISTORY_WIDTH'({bp.updateHistory, bp.taken})
                     : lookup ? HISTORY_WIDTH'({ghr_q, lk_jump}) : ghr_q;
        pred_valid_d = lookup;
        jump_d       = lookup ? lk_jump : jump_q;
        pred_hist_d  = lookup ? ghr_q : pred_hist_q;
    end
endmodule

// File: tb/tb_tournament_predictor.sv
// tb_tournament_predictor: random and directed checks against a table-level reference model
module tb_tournament_predictor;
    localparam int IW = 4;
    localparam int HW = 4;
    localparam int CW = 2;
    localparam int NE = 2 ** IW;
    localparam int NH = 2 ** HW;
    localparam int CMAX = 2 ** CW - 1;
    localparam int CMID = 2 ** (CW - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    int m_bim [NE];
    int m_gsh [NE];
    int m_cho [NE];
    int m_ghr;
    int last_jump, last_ph;

    tournament_predictor_if #(.HISTORY_WIDTH(HW)) bp ();

    tournament_predictor #(.INDEX_WIDTH(IW), .HISTORY_WIDTH(HW), .CNT_WIDTH(CW)) dut (
        .clockIn(clk),
        .resetIn(rst),
        .bp(bp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int train(input int c, input bit t);
        return t ? ((c < CMAX) ? c + 1 : CMAX) : ((c > 0) ? c - 1 : 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_bim[i] = CMID - 1;
            m_gsh[i] = CMID - 1;
            m_cho[i] = CMID - 1;
        end
        m_ghr = 0;
    endtask

    task automatic idle_inputs();
        bp.instrInValid  = 1'b0;
        bp.instrAddr     = '0;
        bp.updateValid   = 1'b0;
        bp.updateInstr   = '0;
        bp.updateHistory = '0;
        bp.taken         = 1'b0;
        bp.mispredict    = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bp.ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, n, NE);
    endtask

    task automatic step(input bit lv, input int la, input bit uv, input int ui,
                        input int uh, input bit t, input bit mp);
        int b, g, ub, ug, ej, eh;
        bit bm, gm;
        bp.instrInValid  = lv;
        bp.instrAddr     = 32'(la);
        bp.updateValid   = uv;
        bp.updateInstr   = 32'(ui);
        bp.updateHistory = HW'(uh);
        bp.taken         = t;
        bp.mispredict    = mp;
        b  = (la / 4) % NE;
        g  = b ^ m_ghr;
        eh = m_ghr;
        ej = (m_cho[b] >= CMID) ? int'(m_gsh[g] >= CMID) : int'(m_bim[b] >= CMID);
        if (uv) begin
            ub = (ui / 4) % NE;
            ug = ub ^ (uh % NH);
            bm = m_bim[ub] >= CMID;
            gm = m_gsh[ug] >= CMID;
            m_bim[ub] = train(m_bim[ub], t);
            m_gsh[ug] = train(m_gsh[ug], t);
            if (bm != gm) m_cho[ub] = train(m_cho[ub], gm == t);
        end
        if (lv) m_ghr = (m_ghr * 2 + ej) % NH;
        if (uv && mp) m_ghr = ((uh % NH) * 2 + int'(t)) % NH;
        @(posedge clk);
        #1;
        chk("ready", int'(bp.ready), 1);
        chk("pred_valid", int'(bp.predValid), int'(lv));
        if (lv) begin
            chk("jump", int'(bp.jump), ej);
            chk("pred_hist", int'(bp.predHistory), eh);
        end
        last_jump = int'(bp.jump);
        last_ph   = int'(bp.predHistory);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #1;
        chk("rst_ready", int'(bp.ready), 0);
        chk("rst_pv", int'(bp.predValid), 0);
        chk("rst_jump", int'(bp.jump), 0);
        chk("rst_ph", int'(bp.predHistory), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("init_len");

        step(1, 'h40, 0, 0, 0, 0, 0);
        chk("first_jump", last_jump, 0);
        chk("first_ph", last_ph, 0);
        step(1, 'h44, 0, 0, 0, 0, 0);
        step(1, 'h48, 0, 0, 0, 0, 0);
        step(0, 0, 1, 'h80, 'h5, 1, 1);
        step(1, 'h4c, 0, 0, 0, 0, 0);
        chk("repair_ph", last_ph, 'hb);

        repeat (4) step(0, 0, 1, 'h100, 0, 1, 0);
        chk("sat_bim", m_bim[0], CMAX);
        step(0, 0, 1, 'h108, 'h5, 1, 1);
        step(1, 'h100, 0, 0, 0, 0, 0);
        chk("trained_jump", last_jump, 1);

        repeat (4) step(0, 0, 1, 'h304, 0, 0, 0);
        chk("floor_bim", m_bim[1], 0);
        step(1, 'h304, 0, 0, 0, 0, 0);

        step(1, 'h208, 1, 'h208, 0, 1, 0);
        step(1, 'h208, 1, 'h208, 0, 1, 0);
        step(1, 'h208, 0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1), int'($urandom_range(0, 63)) * 4,
                 $urandom_range(0, 1), int'($urandom_range(0, 63)) * 4,
                 int'($urandom_range(0, NH - 1)), $urandom_range(0, 1),
                 $urandom_range(0, 3) == 0);
        end

        repeat (3) step(0, 0, 1, 'h100, 0, 1, 0);
        step(1, 'h100, 0, 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_ready", int'(bp.ready), 0);
        chk("async_pv", int'(bp.predValid), 0);
        chk("async_jump", int'(bp.jump), 0);
        chk("async_ph", int'(bp.predHistory), 0);
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("reinit_len");
        step(1, 'h100, 0, 0, 0, 0, 0);
        chk("lost_jump", last_jump, 0);
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 1), int'($urandom_range(0, 63)) * 4,
                 $urandom_range(0, 1), int'($urandom_range(0, 63)) * 4,
                 int'($urandom_range(0, NH - 1)), $urandom_range(0, 1),
                 $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
